// File: rtl/vending_machine_fsm.sv
// Coin-operated vending controller: accumulates credit, vends a selected item,
// and pays change out in bounded chunks. All outputs except sold_out are registered.
module vending_machine_fsm #(
  parameter int N_ITEMS    = 4,
  parameter int COIN_W     = 4,
  parameter int CREDIT_W   = 6,
  parameter logic [N_ITEMS*CREDIT_W-1:0] COST_TABLE = {6'd12, 6'd10, 6'd7, 6'd5},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int CHANGE_MAX = 10,
  localparam int SW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [SW-1:0]       sel_item,
  input  logic                cancel,
  input  logic                restock,
  output logic                dispense,
  output logic [SW-1:0]       dispense_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                sel_fail,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  localparam logic [CREDIT_W-1:0] CHANGE_MAX_C = CREDIT_W'(CHANGE_MAX);
  localparam logic [STOCK_W-1:0]  STOCK_INIT_C = STOCK_W'(STOCK_INIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic [SW-1:0]       dispense_item_q, dispense_item_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_fail_q, sel_fail_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];

  logic [N_ITEMS-1:0]  sel_hit;
  logic [CREDIT_W-1:0] sel_cost;
  logic                sel_in_stock;
  logic                sel_ok;
  logic [N_ITEMS-1:0]  stock_dec;
  logic                restock_en;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] payout;

  // Out-of-range indices match no entry, so they fail the stock test naturally.
  always_comb begin
    sel_hit      = '0;
    sel_cost     = '0;
    sel_in_stock = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_item == SW'(i)) begin
        sel_hit[i]   = 1'b1;
        sel_cost     = COST_TABLE[i*CREDIT_W +: CREDIT_W];
        sel_in_stock = (stock_q[i] != '0);
      end
    end
  end

  assign sel_ok   = sel_in_stock && (credit_q >= sel_cost);
  assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value);
  assign payout   = (credit_q > CHANGE_MAX_C) ? CHANGE_MAX_C : credit_q;

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    dispense_d      = 1'b0;
    dispense_item_d = dispense_item_q;
    change_valid_d  = 1'b0;
    change_amt_d    = '0;
    coin_reject_d   = 1'b0;
    sel_fail_d      = 1'b0;
    stock_dec       = '0;
    restock_en      = 1'b0;
    case (state_q)
      IDLE: begin
        restock_en = restock;
        if (coin_valid && (coin_value != '0)) begin
          credit_d = CREDIT_W'(coin_value);
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          coin_reject_d  = coin_valid;
          state_d        = REFUND;
          change_valid_d = 1'b1;
          change_amt_d   = payout;
          credit_d       = credit_q - payout;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (sel_ok) begin
            state_d         = VEND;
            dispense_d      = 1'b1;
            dispense_item_d = sel_item;
            credit_d        = credit_q - sel_cost;
            stock_dec       = sel_hit;
          end else begin
            sel_fail_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (!coin_sum[CREDIT_W]) credit_d = coin_sum[CREDIT_W-1:0];
          else                     coin_reject_d = 1'b1;
        end
      end
      // VEND and REFUND share the payout step; credit_q already holds what is owed.
      VEND, REFUND: begin
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
          state_d        = REFUND;
          change_valid_d = 1'b1;
          change_amt_d   = payout;
          credit_d       = credit_q - payout;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      change_valid_q  <= 1'b0;
      change_amt_q    <= '0;
      coin_reject_q   <= 1'b0;
      sel_fail_q      <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_INIT_C;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      dispense_q      <= dispense_d;
      dispense_item_q <= dispense_item_d;
      change_valid_q  <= change_valid_d;
      change_amt_q    <= change_amt_d;
      coin_reject_q   <= coin_reject_d;
      sel_fail_q      <= sel_fail_d;
      for (int i = 0; i < N_ITEMS; i++) begin
        if (restock_en)        stock_q[i] <= STOCK_INIT_C;
        else if (stock_dec[i]) stock_q[i] <= stock_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign dispense      = dispense_q;
  assign dispense_item = dispense_item_q;
  assign change_valid  = change_valid_q;
  assign change_amt    = change_amt_q;
  assign coin_reject   = coin_reject_q;
  assign sel_fail      = sel_fail_q;
  assign credit        = credit_q;
  assign busy          = (state_q == VEND) || (state_q == REFUND);

endmodule

// File: doc/vending_machine_fsm.md
VENDING_MACHINE_FSM -- requirements
Module: vending_machine_fsm

Interface
REQ-001 Parameters SHALL be:
- N_ITEMS, 4, number of items.
- COIN_W, 4, coin value width.
- CREDIT_W, 6, credit/cost/change width.
- COST_TABLE, {12,10,7,5}, N_ITEMS*CREDIT_W flat vector; item i cost at [i*CREDIT_W +: CREDIT_W].
- STOCK_W, 4, per-item stock counter width.
- STOCK_INIT, 8, stock loaded at reset/restock.
- CHANGE_MAX, 10, largest change amount paid per cycle.
REQ-002 Ports SHALL be (SW = max(1, clog2(N_ITEMS))):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- coin_valid  in  1  coin present this cycle.
- coin_value  in  COIN_W  coin value.
- sel_valid  in  1  item selection request.
- sel_item  in  SW  selected item index.
- cancel  in  1  abort, refund credit.
- restock  in  1  reload all stock counters.
- dispense  out  1  one-cycle vend pulse.
- dispense_item  out  SW  item being vended.
- change_valid  out  1  change payout this cycle.
- change_amt  out  CREDIT_W  change paid this cycle.
- coin_reject  out  1  one-cycle coin return pulse.
- sel_fail  out  1  one-cycle failed selection pulse.
- sold_out  out  N_ITEMS  bit i high when stock[i]==0.
- credit  out  CREDIT_W  current credit / remaining change.
- busy  out  1  high in VEND or REFUND.

Function
REQ-003 States SHALL be IDLE, COLLECT, VEND, REFUND; all outputs except sold_out SHALL be registered.
REQ-004 IDLE: coin_valid with coin_value>0 SHALL load credit=coin_value and go to COLLECT; coin_value==0 ignored; sel_valid and cancel ignored.
REQ-005 restock SHALL reload every stock counter to STOCK_INIT only in IDLE; ignored in other states.
REQ-006 COLLECT same-cycle priority SHALL be cancel > sel_valid > coin_valid.
REQ-007 cancel in COLLECT SHALL go to REFUND with remaining = credit.
REQ-008 sel_valid in COLLECT with sel_item < N_ITEMS, stock>0 and credit >= cost SHALL go to VEND, set credit = credit - cost, decrement that stock counter, latch dispense_item.
REQ-009 sel_valid failing any REQ-008 condition SHALL pulse sel_fail next cycle, stay in COLLECT, credit unchanged.
REQ-010 Coin in COLLECT SHALL add to credit when credit+coin_value <= 2^CREDIT_W-1 (no wrap); otherwise pulse coin_reject next cycle, credit unchanged.
REQ-011 coin_valid coincident with an acted-on cancel or sel_valid SHALL be rejected (coin_reject pulse).
REQ-012 VEND SHALL last exactly one cycle with dispense=1; dispense SHALL rise the cycle after the accepted selection; next state REFUND if credit>0, else IDLE.
REQ-013 REFUND: each cycle change_valid=1, change_amt = min(credit, CHANGE_MAX), credit reduced by change_amt; leave to IDLE in the cycle credit reaches 0.
REQ-014 Coins in VEND or REFUND SHALL be rejected; sel_valid, cancel, restock ignored.
REQ-015 change_amt SHALL be 0 whenever change_valid=0; dispense_item holds last value.
REQ-016 sold_out SHALL be combinational from stock counters.

Reset
REQ-017 reset low SHALL asynchronously force IDLE, credit=0, all pulse outputs 0, change_amt=0, dispense_item=0, every stock counter=STOCK_INIT, including mid-VEND/REFUND (pending change discarded).
REQ-018 Operation SHALL resume on the first rising clk edge with reset high.

Verification
REQ-019 Default parameters; coin 5, then sel_item 0 -> dispense=1, dispense_item=0 one cycle later, no change_valid, IDLE, sold_out=0, stock[0]=7.
REQ-020 Coins 10,10 then select item 3 -> dispense, next cycle change_valid=1 change_amt=8, then IDLE.
REQ-021 Coins 15,10 (credit 25) then cancel -> change_amt 10,10,5 on three consecutive cycles, credit 0, IDLE.
REQ-022 Credit 60, coin 5 -> coin_reject pulse, credit stays 60; coin 3 -> credit 63.
REQ-023 Vend item 1 eight times -> sold_out[1]=1; ninth select with credit 7 -> sel_fail, credit 7 retained; cancel, refund, restock in IDLE -> sold_out[1]=0.
REQ-024 Credit 30 cancel, reset low during second REFUND cycle -> immediately change_valid=0, credit=0, IDLE, stocks=8.
